// File: rtl/nios_system_irq_pkg.sv
// Shared constants and write-decode helper for the Nios interrupt aggregator.
package nios_system_irq_pkg;

    typedef enum logic [2:0] {
        ADDR_PENDING  = 3'd0,
        ADDR_MASK     = 3'd1,
        ADDR_EDGE_SEL = 3'd2,
        ADDR_ACTIVE   = 3'd3,
        ADDR_RAW      = 3'd4,
        ADDR_STATS    = 3'd5
    } irq_addr_e;

    localparam int ACTIVE_VALID_BIT = 15;
    localparam int STATS_W          = 16;

    typedef struct packed {
        logic pending;
        logic mask;
        logic edge_sel;
        logic stats;
    } irq_wr_t;

    function automatic irq_wr_t decode_wr(input logic strobe, input logic [2:0] addr);
        irq_wr_t d;
        d.pending  = strobe && (addr == ADDR_PENDING);
        d.mask     = strobe && (addr == ADDR_MASK);
        d.edge_sel = strobe && (addr == ADDR_EDGE_SEL);
        d.stats    = strobe && (addr == ADDR_STATS);
        return d;
    endfunction

endpackage

// File: rtl/nios_system_irq_sync.sv
// Per-line two-flop synchroniser with a history flop; rise is the
// single-cycle rising-edge strobe of the synchronised line.
module nios_system_irq_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic irq_in,
    output logic s2,
    output logic rise
);

    logic s1;
    logic s2_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s2_d <= 1'b0;
        end else begin
            s1   <= irq_in;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    assign rise = s2 & ~s2_d;

endmodule

// File: rtl/nios_system_irq_ctrl.sv
// Avalon-MM interrupt aggregator: sync, level/edge latch, mask, priority encode.
// Define NIOS_IRQ_CTRL_STATS_EN to add the irq_out assertion counter at address 5.
module nios_system_irq_ctrl
    import nios_system_irq_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int DATA_W  = 16,
    parameter int ID_W    = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic              irq_out
);

    logic [NUM_IRQ-1:0] s2, rise;
    logic [NUM_IRQ-1:0] pending, mask, edge_sel;
    logic [NUM_IRQ-1:0] edge_nxt, pend_nxt, act_vec;
    logic [NUM_IRQ-1:0] wd;
    logic [ID_W-1:0]    act_id;
    logic               act_vld;
    logic               irq_nxt;
    logic [DATA_W-1:0]  rd_nxt, stats_rd;
    irq_wr_t            wr;

    assign wd = writedata[NUM_IRQ-1:0];
    assign wr = decode_wr(chipselect && !write_n, address);

    generate
        for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
            nios_system_irq_sync u_sync (
                .clk     (clk),
                .reset_n (reset_n),
                .irq_in  (irq_in[i]),
                .s2      (s2[i]),
                .rise    (rise[i])
            );
        end
        if (DATA_W > NUM_IRQ) begin : g_wd_hi
            logic wd_hi_unused;
            assign wd_hi_unused = ^writedata[DATA_W-1:NUM_IRQ];
        end
    endgenerate

    // Mode is taken from the value being written so an edge->level switch
    // reloads pending from s2 at the same edge as the EDGE_SEL write.
    always_comb begin
        edge_nxt = wr.edge_sel ? wd : edge_sel;
        pend_nxt = pending;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (!edge_nxt[i])
                pend_nxt[i] = s2[i];
            else if (rise[i])
                pend_nxt[i] = 1'b1;
            else if (wr.pending && wd[i])
                pend_nxt[i] = 1'b0;
        end
    end

    assign act_vec = pending & mask;
    assign irq_nxt = |act_vec;

    // Descending scan so the lowest-index active line is the last to win.
    always_comb begin
        act_id  = '0;
        act_vld = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (act_vec[i]) begin
                act_id  = ID_W'(i);
                act_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask     <= '0;
            edge_sel <= '0;
            pending  <= '0;
            irq_out  <= 1'b0;
        end else begin
            if (wr.mask)
                mask <= wd;
            edge_sel <= edge_nxt;
            pending  <= pend_nxt;
            irq_out  <= irq_nxt;
        end
    end

`ifdef NIOS_IRQ_CTRL_STATS_EN
    logic [STATS_W-1:0] stats_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stats_cnt <= '0;
        else if (wr.stats)
            stats_cnt <= '0;
        else if (irq_nxt && !irq_out && stats_cnt != '1)
            stats_cnt <= stats_cnt + 1'b1;
    end

    assign stats_rd = DATA_W'(stats_cnt);
`else
    assign stats_rd = '0;
`endif

    always_comb begin
        rd_nxt = '0;
        case (address)
            ADDR_PENDING:  rd_nxt = DATA_W'(pending);
            ADDR_MASK:     rd_nxt = DATA_W'(mask);
            ADDR_EDGE_SEL: rd_nxt = DATA_W'(edge_sel);
            ADDR_ACTIVE: begin
                rd_nxt[ACTIVE_VALID_BIT] = act_vld;
                rd_nxt[ID_W-1:0]         = act_id;
            end
            ADDR_RAW:      rd_nxt = DATA_W'(s2);
            ADDR_STATS:    rd_nxt = stats_rd;
            default:       rd_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            readdata <= '0;
        else
            readdata <= rd_nxt;
    end

endmodule
